program_memory_host: RTL

- Host-side counterpart to `computer`; implements the far end of the computer's memory bus (addr/we/odata/idata) plus the start/halt handshake.
- Owns a DEPTH x DW byte memory with three phases:
  - LOAD: a program image is streamed in.
  - RUN: holds `start` and services CPU reads and writes until `halt`.
  - DUMP: streams the final memory image out for checking.
- Replaces the behavioural memory model with synthesizable RTL usable on silicon/FPGA and in self-checking benches.

---
 rtl/program_memory_host.sv | 123 ++++++++++++
 1 files changed

// File: rtl/program_memory_host.sv
// Host-side program memory for the computer core.
// Streams an image in, serves the CPU until halt or timeout, then streams it out.
module program_memory_host #(
  parameter int DW          = 8,
  parameter int AW          = 5,
  parameter int DEPTH       = 32,
  parameter int RUN_TIMEOUT = 100
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          cpu_start,
  input  logic          cpu_halt,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          dp_valid,
  output logic [DW-1:0] dp_data,
  output logic          dp_last,
  input  logic          dp_ready,
  output logic          timeout,
  output logic [1:0]    phase
);

  localparam int CW = $clog2(RUN_TIMEOUT + 1);
  localparam logic [CW-1:0] RT_LAST = CW'(RUN_TIMEOUT - 1);
  localparam logic [AW-1:0] P_LAST  = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    LOAD = 2'b00,
    RUN  = 2'b01,
    DUMP = 2'b10
  } phase_t;

  phase_t        state;
  logic [AW-1:0] ptr;
  logic [CW-1:0] run_cnt;
  logic          ptr_last;

  logic [DW-1:0] mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  assign ptr_last  = (ptr == P_LAST);
  assign ld_ready  = (state == LOAD);
  assign cpu_start = (state == RUN);
  assign dp_valid  = (state == DUMP);
  assign dp_last   = dp_valid & ptr_last;
  assign dp_data   = mem[ptr];
  assign cpu_rdata = mem[cpu_addr];
  assign phase     = state;

  // Single write port shared by the loader and the CPU.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ptr;
    mem_wdata = ld_data;
    if (state == LOAD && ld_valid) begin
      mem_we = 1'b1;
    end else if (state == RUN && cpu_we) begin
      mem_we    = 1'b1;
      mem_waddr = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  // Contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOAD;
      ptr     <= '0;
      run_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      unique case (1'b1)
        state == LOAD: begin
          if (ld_valid) begin
            if (ptr_last) begin
              ptr     <= '0;
              run_cnt <= '0;
              timeout <= 1'b0;
              state   <= RUN;
            end else begin
              ptr <= ptr + AW'(1);
            end
          end
        end
        state == RUN: begin
          run_cnt <= run_cnt + CW'(1);
          // A halt left over from before start is ignored.
          if (cpu_halt && run_cnt != '0) begin
            state <= DUMP;
          end else if (run_cnt == RT_LAST) begin
            state   <= DUMP;
            timeout <= 1'b1;
          end
        end
        state == DUMP: begin
          if (dp_ready) begin
            if (ptr_last) begin
              ptr     <= '0;
              run_cnt <= '0;
              state   <= LOAD;
            end else begin
              ptr <= ptr + AW'(1);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
